spi_ram_master: RTL and testbench

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

---
 rtl/spi_ram_pkg.sv | 37 +++
 rtl/spi_frame_engine.sv | 94 +++++++++
 rtl/spi_ram_master.sv | 124 ++++++++++++
 tb/tb_spi_ram_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: frame op codes, frame lengths,
// sequencer states and the per-cycle MOSI bit lookup.
package spi_ram_pkg;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  localparam logic [4:0] FRAME_LEN    = 5'd12;
  localparam logic [4:0] RD_FRAME_LEN = 5'd21;
  localparam logic [4:0] RX_FIRST     = 5'd13;

  typedef enum logic [2:0] {
    IDLE,
    FRAME1,
    GAP1,
    FRAME2,
    DONE
  } state_e;

  // MOSI for frame cycle idx: code[1] x3, code[0], payload MSB first, then zeros.
  function automatic logic frame_mosi(input logic [1:0] code,
                                      input logic [7:0] payload,
                                      input logic [4:0] idx);
    if (idx < 5'd3) begin
      return code[1];
    end else if (idx == 5'd3) begin
      return code[0];
    end else if (idx < FRAME_LEN) begin
      return payload[3'd7 - 3'(idx - 5'd4)];
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// Serialises one SPI frame; SS_n/MOSI are registered so the first frame cycle
// appears on the pins in the cycle right after start_i.
module spi_frame_engine
  import spi_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] code_i,
  input  logic [7:0] payload_i,
  input  logic       is_rd_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       ss_n_o,
  output logic       mosi_o,
  output logic [7:0] rx_byte_o
);

  logic       busy_q, busy_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic [7:0] payload_q, payload_d;
  logic       is_rd_q, is_rd_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic [7:0] rx_q, rx_d;
  logic [4:0] last_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      cnt_q     <= 5'd0;
      code_q    <= 2'b00;
      payload_q <= 8'h00;
      is_rd_q   <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      rx_q      <= 8'h00;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      payload_q <= payload_d;
      is_rd_q   <= is_rd_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      rx_q      <= rx_d;
    end
  end

  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    payload_d    = payload_q;
    is_rd_d      = is_rd_q;
    ss_n_d       = ss_n_q;
    mosi_d       = mosi_q;
    rx_d         = rx_q;
    last_idx     = is_rd_q ? (RD_FRAME_LEN - 5'd1) : (FRAME_LEN - 5'd1);
    frame_done_o = busy_q && (cnt_q == last_idx);
    // Complete byte including the bit sampled on the final edge of the frame.
    rx_byte_o    = {rx_q[6:0], miso_i};

    if (start_i) begin
      busy_d    = 1'b1;
      cnt_d     = 5'd0;
      code_d    = code_i;
      payload_d = payload_i;
      is_rd_d   = is_rd_i;
      ss_n_d    = 1'b0;
      mosi_d    = frame_mosi(code_i, payload_i, 5'd0);
      rx_d      = 8'h00;
    end else if (busy_q) begin
      if (is_rd_q && cnt_q >= RX_FIRST) begin
        rx_d = {rx_q[6:0], miso_i};
      end
      if (frame_done_o) begin
        busy_d = 1'b0;
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 5'd1;
        mosi_d = frame_mosi(code_q, payload_q, cnt_q + 5'd1);
      end
    end
  end

  assign busy_o = busy_q;
  assign ss_n_o = ss_n_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/spi_ram_master.sv
// Turns one write/read request into an address frame plus a data frame on an
// SPI RAM, with a single SS_n-high gap between frames and after the transaction.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic       eng_start;
  logic [1:0] eng_code;
  logic [7:0] eng_payload;
  logic       eng_is_rd;
  logic       eng_busy;
  logic       eng_frame_done;
  logic [7:0] eng_rx_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    eng_start   = 1'b0;
    eng_code    = WR_ADDR;
    eng_payload = addr_q;
    eng_is_rd   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          eng_start   = 1'b1;
          eng_code    = req_we ? WR_ADDR : RD_ADDR;
          eng_payload = req_addr;
          state_d     = FRAME1;
        end
      end
      FRAME1: begin
        if (eng_frame_done) state_d = GAP1;
      end
      GAP1: begin
        if (!eng_busy) begin
          eng_start   = 1'b1;
          eng_code    = we_q ? WR_DATA : RD_DATA;
          eng_payload = we_q ? wdata_q : 8'h00;
          eng_is_rd   = !we_q;
          state_d     = FRAME2;
        end
      end
      FRAME2: begin
        if (eng_frame_done) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = eng_rx_byte;
        end
      end
      // DONE is also the post-transaction gap, so a held request waits for IDLE.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  spi_frame_engine u_engine (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (eng_start),
    .code_i       (eng_code),
    .payload_i    (eng_payload),
    .is_rd_i      (eng_is_rd),
    .miso_i       (MISO),
    .busy_o       (eng_busy),
    .frame_done_o (eng_frame_done),
    .ss_n_o       (SS_n),
    .mosi_o       (MOSI),
    .rx_byte_o    (eng_rx_byte)
  );

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Random write/read traffic against a behavioural SPI RAM slave; a scoreboard
// checks latency, read data and the decoded frames of every transaction.
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata, rdata;
  logic       done, SS_n, MOSI;
  logic       MISO = 1'b0;

  always #5 clk = ~clk;

  spi_ram_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         acc;
  } exp_t;

  typedef struct {
    logic [1:0] code;
    logic [7:0] payload;
    int         len;
    logic       err;
  } frm_t;

  exp_t       exp_q[$];
  frm_t       obs_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         txn = 0;
  int         done_cnt = 0;
  int         prev_acc = 0;
  logic       prev_we = 1'b0;
  bit         prev_held = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] slv_mem [256];
  logic       s_err = 1'b0;
  logic       ready_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Behavioural SPI RAM slave: decodes frames on rising edges, drives MISO.
  int         sk = 0;
  logic [20:0] sbits;
  logic [7:0] s_wa = 8'h00, s_rd = 8'h00;
  logic       s_prev_ss = 1'b1;
  always @(posedge clk) begin
    frm_t f;
    int   flen;
    if (rst) begin
      sk = 0; s_prev_ss = 1'b1; s_err = 1'b0;
      obs_q.delete();
      MISO <= 1'b0;
    end else begin
      if (SS_n == 1'b0) begin
        if (sk == 0 && s_prev_ss == 1'b0) s_err = 1'b1;
        sbits[sk] = MOSI;
        if (sk >= 12 && sk <= 19) MISO <= s_rd[19 - sk];
        else MISO <= 1'b0;
        sk++;
        if (sk >= 4) begin
          flen = ({sbits[0], sbits[3]} == 2'b11) ? 21 : 12;
          if (sk == flen) begin
            f.code = {sbits[0], sbits[3]};
            f.len  = flen;
            f.err  = (sbits[1] != sbits[0]) || (sbits[2] != sbits[0]);
            for (int i = 0; i < 8; i++) f.payload[7 - i] = sbits[4 + i];
            for (int i = 12; i < flen; i++) if (sbits[i] != 1'b0) f.err = 1'b1;
            case (f.code)
              2'b00: s_wa = f.payload;
              2'b01: slv_mem[s_wa] = f.payload;
              2'b10: s_rd = slv_mem[f.payload];
              default: ;
            endcase
            obs_q.push_back(f);
            sk = 0;
          end
        end
      end else if (sk != 0) begin
        s_err = 1'b1;
        sk = 0;
      end
      s_prev_ss = SS_n;
    end
  end

  // Monitor: pops the scoreboard whenever done pulses.
  always @(negedge clk) begin
    exp_t e;
    frm_t f1, f2;
    if (req_ready && (!SS_n || done)) ready_bad = 1'b1;
    if (done === 1'b1 && !rst) begin
      done_cnt++;
      check("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("latency", 32'(cyc - e.acc), e.we ? 32'd25 : 32'd34);
        check("rdata", 32'(rdata), 32'(e.rdata));
        check("frames_seen", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
          f1 = obs_q.pop_front();
          f2 = obs_q.pop_front();
          check("frame1", {16'h0, f1.code, f1.payload, 5'(f1.len), f1.err},
                {16'h0, (e.we ? 2'b00 : 2'b10), e.addr, 5'd12, 1'b0});
          check("frame2", {16'h0, f2.code, f2.payload, 5'(f2.len), f2.err},
                {16'h0, (e.we ? 2'b01 : 2'b11), (e.we ? e.wdata : 8'h00),
                 (e.we ? 5'd12 : 5'd21), 1'b0});
        end
        check("protocol", {30'h0, s_err, ready_bad}, 32'd0);
        s_err = 1'b0;
        ready_bad = 1'b0;
        $display("txn %0d %s addr=%02h wdata=%02h rdata=%02h exp=%02h", txn,
                 e.we ? "WR" : "RD", e.addr, e.wdata, rdata, e.rdata);
        txn++;
      end
    end
  end

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input bit hold);
    exp_t e;
    int   w = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (req_ready !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 100) begin
        check("ready_timeout", 32'(w), 32'd0);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.we = we; e.addr = addr; e.wdata = wdata; e.acc = cyc;
    if (we) begin
      ref_mem[addr] = wdata;
      e.rdata = last_rd;
    end else begin
      e.rdata = ref_mem[addr];
      last_rd = ref_mem[addr];
    end
    exp_q.push_back(e);
    if (prev_held) check("b2b_spacing", 32'(e.acc - prev_acc), prev_we ? 32'd27 : 32'd36);
    prev_acc = e.acc; prev_we = we; prev_held = hold;
    // Inputs change after acceptance; the frames must still carry accepted values.
    req_addr = 8'($urandom); req_wdata = 8'($urandom); req_we = 1'($urandom);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    int         d0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    issue(1'b1, 8'h3C, 8'hA5, 0);
    issue(1'b0, 8'h3C, 8'h00, 0);

    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      issue(1'b1, a, d, 0);
      issue(1'b0, a, 8'h00, 0);
    end
    drain();

    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom), 8'($urandom), 8'($urandom), i != 23);
    end
    drain();

    // Abort a write in the middle of its data frame.
    req_we = 1'b1; req_addr = 8'h77; req_wdata = 8'h11; req_valid = 1'b1;
    while (req_ready !== 1'b1) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("abort_ss_low_before", 32'(SS_n), 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_ss_n", 32'(SS_n), 32'd1);
    check("abort_mosi", 32'(MOSI), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = 8'h00;
    prev_held = 0;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);

    issue(1'b0, 8'h77, 8'h00, 0);
    issue(1'b1, 8'h5E, 8'hC3, 0);
    issue(1'b0, 8'h5E, 8'h00, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
